ex_stage: RTL and testbench

- Execute stage; consumes the ID/EX register bundle: control bits, add_pc, data1/data2, sign-extended immediate, rt/rd, funct.
- Performs ALU operation, operand/destination selection and branch-target computation.
- Drives the EX/MEM register, registered inside this block.
- Optional multi-cycle multiplier; while it runs, the block stalls the front end via stall_req.

---
 rtl/ex_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, operand/destination select, branch target and the EX/MEM register.
// Define EX_STAGE_MULT_EN to add the shift-add multiplier (funct 011000) that stalls the front end.
module ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              flush,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic              Branch,
   input  logic [2:0]        AluOP,
   input  logic              ALUSrc,
   input  logic              RegDst,
   input  logic [DATA_W-1:0] add_pc,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic [DATA_W-1:0] sign_ex,
   input  logic [REG_W-1:0]  rt,
   input  logic [REG_W-1:0]  rd,
   input  logic [5:0]        funct,
   output logic              stall_req,
   output logic              out_valid,
   output logic              o_RegWrite,
   output logic              o_MemtoReg,
   output logic              o_MemWrite,
   output logic              o_MemRead,
   output logic              o_branch_taken,
   output logic [DATA_W-1:0] o_branch_target,
   output logic [DATA_W-1:0] o_alu_result,
   output logic [DATA_W-1:0] o_store_data,
   output logic [REG_W-1:0]  o_wr_reg
);

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_RTYPE = 3'b010;
   localparam logic [2:0] OP_AND   = 3'b011;
   localparam logic [2:0] OP_OR    = 3'b100;
   localparam logic [2:0] OP_SLT   = 3'b101;
   localparam logic [2:0] OP_LUI   = 3'b110;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] br_target;
   logic [REG_W-1:0]  wr_reg;
   logic              alu_legal;
   logic              zero;
   logic              take_single;

   assign op_b      = ALUSrc ? sign_ex : data2;
   assign wr_reg    = RegDst ? rd : rt;
   assign zero      = (data1 == op_b);
   assign br_target = add_pc + (sign_ex << 2);

`ifdef EX_STAGE_MULT_EN
   localparam logic [5:0] FN_MULT = 6'b011000;
   logic is_mult;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      alu_res   = '0;
      alu_legal = 1'b1;
`ifdef EX_STAGE_MULT_EN
      is_mult   = 1'b0;
`endif
      case (AluOP)
         OP_ADD: alu_res = data1 + op_b;
         OP_SUB: alu_res = data1 - op_b;
         OP_AND: alu_res = data1 & op_b;
         OP_OR:  alu_res = data1 | op_b;
         OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(data1) < $signed(op_b)};
         OP_LUI: alu_res = op_b << 16;
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_res = data1 + op_b;
               FN_SUB:  alu_res = data1 - op_b;
               FN_AND:  alu_res = data1 & op_b;
               FN_OR:   alu_res = data1 | op_b;
               FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(data1) < $signed(op_b)};
`ifdef EX_STAGE_MULT_EN
               FN_MULT: is_mult = 1'b1;
`endif
               default: alu_legal = 1'b0;
            endcase
         end
         default: alu_legal = 1'b0;
      endcase
   end

`ifdef EX_STAGE_MULT_EN
   // Bit 0 of the multiplier is folded into the start edge, so MUL lasts 31 cycles
   // (cnt 1..31) and the product lands 32 edges after the mult is first presented.
   typedef enum logic {IDLE, MUL} state_t;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_write;
      logic              mem_read;
      logic              branch_taken;
      logic [REG_W-1:0]  wr_reg;
      logic [DATA_W-1:0] store_data;
      logic [DATA_W-1:0] branch_target;
   } hold_t;

   state_t            state, state_nxt;
   logic [4:0]        cnt;
   logic [DATA_W-1:0] mcand, mplier, acc, pp, acc_sum;
   hold_t             held;
   logic              start, mul_done;

   assign start       = (state == IDLE) && in_valid && !flush && is_mult;
   assign mul_done    = (state == MUL) && !flush && (cnt == 5'd31);
   assign take_single = (state == IDLE) && in_valid && !flush && !is_mult;
   assign pp          = mplier[cnt] ? (mcand << cnt) : '0;
   assign acc_sum     = acc + pp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_req = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = MUL;
               stall_req = 1'b1;
            end
         end
         MUL: begin
            if (flush || cnt == 5'd31) state_nxt = IDLE;
            else                       stall_req = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         held   <= '0;
      end else if (start) begin
         mcand              <= data1;
         mplier             <= op_b;
         acc                <= op_b[0] ? data1 : '0;
         cnt                <= 5'd1;
         held.reg_write     <= RegWrite;
         held.mem_to_reg    <= MemtoReg;
         held.mem_write     <= MemWrite;
         held.mem_read      <= MemRead;
         held.branch_taken  <= Branch & zero;
         held.wr_reg        <= wr_reg;
         held.store_data    <= data2;
         held.branch_target <= br_target;
      end else if (state == MUL) begin
         acc <= acc_sum;
         cnt <= cnt + 5'd1;
      end
   end
`else
   assign take_single = in_valid && !flush;
   assign stall_req   = 1'b0;
`endif

   // EX/MEM register: control bits clear on every non-issuing edge; data fields hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         o_RegWrite      <= 1'b0;
         o_MemtoReg      <= 1'b0;
         o_MemWrite      <= 1'b0;
         o_MemRead       <= 1'b0;
         o_branch_taken  <= 1'b0;
         o_branch_target <= '0;
         o_alu_result    <= '0;
         o_store_data    <= '0;
         o_wr_reg        <= '0;
      end else begin
         // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
         out_valid      <= 1'b0;
         o_RegWrite     <= 1'b0;
         o_MemtoReg     <= 1'b0;
         o_MemWrite     <= 1'b0;
         o_MemRead      <= 1'b0;
         o_branch_taken <= 1'b0;
         if (take_single) begin
            out_valid       <= 1'b1;
            o_RegWrite      <= RegWrite & alu_legal;
            o_MemtoReg      <= MemtoReg;
            o_MemWrite      <= MemWrite;
            o_MemRead       <= MemRead;
            o_branch_taken  <= Branch & zero;
            o_branch_target <= br_target;
            o_alu_result    <= alu_res;
            o_store_data    <= data2;
            o_wr_reg        <= wr_reg;
         end
`ifdef EX_STAGE_MULT_EN
         else if (mul_done) begin
            out_valid       <= 1'b1;
            o_RegWrite      <= held.reg_write;
            o_MemtoReg      <= held.mem_to_reg;
            o_MemWrite      <= held.mem_write;
            o_MemRead       <= held.mem_read;
            o_branch_taken  <= held.branch_taken;
            o_branch_target <= held.branch_target;
            o_alu_result    <= acc_sum;
            o_store_data    <= held.store_data;
            o_wr_reg        <= held.wr_reg;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: hand-computed vector table, randomized ops against an
// arithmetic reference model, reset and (with EX_STAGE_MULT_EN) multiplier sequences.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, flush;
   logic        RegWrite, MemtoReg, MemWrite, MemRead, Branch;
   logic [2:0]  AluOP;
   logic        ALUSrc, RegDst;
   logic [31:0] add_pc, data1, data2, sign_ex;
   logic [4:0]  rt, rd;
   logic [5:0]  funct;
   logic        stall_req, out_valid;
   logic        o_RegWrite, o_MemtoReg, o_MemWrite, o_MemRead, o_branch_taken;
   logic [31:0] o_branch_target, o_alu_result, o_store_data;
   logic [4:0]  o_wr_reg;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
      .Branch(Branch), .AluOP(AluOP), .ALUSrc(ALUSrc), .RegDst(RegDst),
      .add_pc(add_pc), .data1(data1), .data2(data2), .sign_ex(sign_ex),
      .rt(rt), .rd(rd), .funct(funct),
      .stall_req(stall_req), .out_valid(out_valid),
      .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg), .o_MemWrite(o_MemWrite),
      .o_MemRead(o_MemRead), .o_branch_taken(o_branch_taken),
      .o_branch_target(o_branch_target), .o_alu_result(o_alu_result),
      .o_store_data(o_store_data), .o_wr_reg(o_wr_reg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid, flush, rw, m2r, mw, mr, br;
      logic [2:0]  op;
      logic        src, dst;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rt, rd;
      logic [5:0]  fn;
   } stim_t;

   typedef struct {
      logic        valid, rw, m2r, mw, mr, bt;
      logic [31:0] target, result, store;
      logic [4:0]  wr;
   } exp_t;

   typedef struct {
      string name;
      stim_t s;
      exp_t  e;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic apply(input stim_t s);
      in_valid = s.in_valid; flush = s.flush;
      RegWrite = s.rw; MemtoReg = s.m2r; MemWrite = s.mw; MemRead = s.mr; Branch = s.br;
      AluOP = s.op; ALUSrc = s.src; RegDst = s.dst;
      add_pc = s.pc; data1 = s.d1; data2 = s.d2; sign_ex = s.imm;
      rt = s.rt; rd = s.rd; funct = s.fn;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input exp_t e);
      check({tag, ".valid"}, out_valid, e.valid);
      check({tag, ".RegWrite"}, o_RegWrite, e.rw);
      check({tag, ".MemtoReg"}, o_MemtoReg, e.m2r);
      check({tag, ".MemWrite"}, o_MemWrite, e.mw);
      check({tag, ".MemRead"}, o_MemRead, e.mr);
      check({tag, ".branch_taken"}, o_branch_taken, e.bt);
      if (e.valid) begin
         check({tag, ".branch_target"}, o_branch_target, e.target);
         check({tag, ".alu_result"}, o_alu_result, e.result);
         check({tag, ".store_data"}, o_store_data, e.store);
         check({tag, ".wr_reg"}, o_wr_reg, e.wr);
      end
   endtask

   function automatic stim_t nop_stim();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t valid_stim();
      stim_t s;
      s = '{default: '0};
      s.in_valid = 1'b1;
      return s;
   endfunction

   function automatic exp_t mk_exp(bit v, bit rw, bit m2r, bit mw, bit mr, bit bt,
                                   logic [31:0] tgt, logic [31:0] res, logic [31:0] st,
                                   logic [4:0] wr);
      exp_t e;
      e.valid = v; e.rw = rw; e.m2r = m2r; e.mw = mw; e.mr = mr; e.bt = bt;
      e.target = tgt; e.result = res; e.store = st; e.wr = wr;
      return e;
   endfunction

   function automatic void add_vec(string n, stim_t s, exp_t e);
      vec_t v;
      v.name = n; v.s = s; v.e = e;
      vecs.push_back(v);
   endfunction

   // Reference model: instruction semantics in plain integer arithmetic.
   function automatic exp_t model(stim_t s);
      exp_t        e;
      bit [31:0]   a, b, r;
      bit          legal;
      e = '{default: '0};
      if (!s.in_valid || s.flush) return e;
      a = s.d1;
      b = s.src ? s.imm : s.d2;
      r = 0;
      legal = 1'b1;
      case (s.op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         3'd6: r = b * 32'd65536;
         3'd2: begin
            case (s.fn)
               6'h20: r = a + b;
               6'h22: r = a - b;
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef EX_STAGE_MULT_EN
               6'h18: r = a * b;
`endif
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      e.valid  = 1'b1;
      e.rw     = s.rw & legal;
      e.m2r    = s.m2r;
      e.mw     = s.mw;
      e.mr     = s.mr;
      e.bt     = s.br && (a == b);
      e.target = s.pc + s.imm * 32'd4;
      e.result = legal ? r : 32'd0;
      e.store  = s.d2;
      e.wr     = s.dst ? s.rd : s.rt;
      return e;
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      stim_t       s, s2;
      logic [5:0]  fns [8];
      int          stalls, bubbles_bad;

      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h00, 6'h3F};

      // ---- vector table (expected values computed by hand) ----
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h20; s.d1 = 5; s.d2 = 7; s.dst = 1; s.rd = 9; s.rt = 4; s.rw = 1;
      add_vec("r_add", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd12, 32'd7, 5'd9));
      s = valid_stim(); s.op = 3'b001; s.br = 1; s.d1 = 3; s.d2 = 3; s.pc = 32'h100; s.imm = 4; s.rt = 5;
      add_vec("beq_taken", s, mk_exp(1, 0, 0, 0, 0, 1, 32'h110, 32'h0, 32'd3, 5'd5));
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h2A; s.d1 = 32'hFFFF_FFFF; s.d2 = 1; s.dst = 1; s.rd = 2; s.rw = 1;
      add_vec("slt_neg", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd1, 32'd1, 5'd2));
      s = valid_stim(); s.op = 3'b000; s.src = 1; s.d1 = 32'h40; s.imm = 8; s.d2 = 32'hAB; s.mw = 1; s.rt = 7; s.pc = 32'h200;
      add_vec("sw", s, mk_exp(1, 0, 0, 1, 0, 0, 32'h220, 32'h48, 32'hAB, 5'd7));
      s.flush = 1;
      add_vec("sw_flush", s, mk_exp(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      s = valid_stim(); s.op = 3'b110; s.src = 1; s.imm = 32'h1234; s.rw = 1; s.rt = 8; s.d1 = 32'h55;
      add_vec("lui", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h48D0, 32'h1234_0000, 32'h0, 5'd8));
      s = valid_stim(); s.op = 3'b111; s.rw = 1; s.d1 = 1; s.d2 = 2; s.rt = 3;
      add_vec("op111", s, mk_exp(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd2, 5'd3));
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h00; s.rw = 1; s.m2r = 1; s.d1 = 4; s.d2 = 4; s.dst = 1; s.rd = 10;
      add_vec("r_unlisted", s, mk_exp(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'd4, 5'd10));
      s = nop_stim(); s.rw = 1; s.mr = 1; s.d1 = 1;
      add_vec("bubble", s, mk_exp(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      s = valid_stim(); s.op = 3'b011; s.d1 = 32'hF0F0_F0F0; s.d2 = 32'hFF00_FF00; s.rw = 1; s.mr = 1; s.m2r = 1; s.rt = 11;
      add_vec("and", s, mk_exp(1, 1, 1, 0, 1, 0, 32'h0, 32'hF000_F000, 32'hFF00_FF00, 5'd11));
      s = valid_stim(); s.op = 3'b100; s.src = 1; s.d1 = 32'h0F; s.imm = 32'hFFFF_FFF0; s.rw = 1; s.rt = 12; s.d2 = 5;
      add_vec("ori", s, mk_exp(1, 1, 0, 0, 0, 0, 32'hFFFF_FFC0, 32'hFFFF_FFFF, 32'd5, 5'd12));
      s = valid_stim(); s.op = 3'b001; s.d1 = 0; s.d2 = 1; s.br = 1; s.pc = 32'h1000; s.imm = 32'hFFFF_FFFF; s.rt = 1;
      add_vec("sub_wrap", s, mk_exp(1, 0, 0, 0, 0, 0, 32'hFFC, 32'hFFFF_FFFF, 32'd1, 5'd1));
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h20; s.d1 = 32'hFFFF_FFFF; s.d2 = 2; s.rw = 1; s.dst = 1; s.rd = 31;
      add_vec("add_ovf", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd1, 32'd2, 5'd31));
      s = valid_stim(); s.op = 3'b001; s.src = 1; s.br = 1; s.d1 = 32'h10; s.imm = 32'h10; s.d2 = 32'h99;
      add_vec("beq_imm", s, mk_exp(1, 0, 0, 0, 0, 1, 32'h40, 32'h0, 32'h99, 5'd0));
      s = valid_stim(); s.op = 3'b101; s.d1 = 5; s.d2 = 32'hFFFF_FFFF; s.rw = 1; s.rt = 6;
      add_vec("slt_signed", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd0, 32'hFFFF_FFFF, 5'd6));
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h22; s.d1 = 10; s.d2 = 3; s.rw = 1; s.dst = 1; s.rd = 13;
      add_vec("r_sub", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd7, 32'd3, 5'd13));
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h24; s.d1 = 12; s.d2 = 10; s.rw = 1; s.dst = 1; s.rd = 14;
      add_vec("r_and", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd8, 32'd10, 5'd14));
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h25; s.d1 = 12; s.d2 = 10; s.rw = 1; s.dst = 1; s.rd = 15;
      add_vec("r_or", s, mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd14, 32'd10, 5'd15));

      // ---- power-on reset ----
      rst_n = 1'b0;
      apply(nop_stim());
      repeat (2) step();
      check_out("reset", mk_exp(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
      check("reset.alu_result", o_alu_result, 32'h0);
      check("reset.stall_req", stall_req, 1'b0);
      rst_n = 1'b1;

      // ---- table ----
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].s);
         step();
         check_out(vecs[i].name, vecs[i].e);
      end

      // ---- asynchronous reset mid-run ----
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h20; s.d1 = 100; s.d2 = 23; s.rw = 1; s.mr = 1;
      s.dst = 1; s.rd = 17; s.pc = 32'h40; s.imm = 1;
      apply(s);
      step();
      check_out("pre_rst", mk_exp(1, 1, 0, 0, 1, 0, 32'h44, 32'd123, 32'd23, 5'd17));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async.valid", out_valid, 1'b0);
      check("rst_async.RegWrite", o_RegWrite, 1'b0);
      check("rst_async.MemRead", o_MemRead, 1'b0);
      check("rst_async.branch_target", o_branch_target, 32'h0);
      check("rst_async.alu_result", o_alu_result, 32'h0);
      check("rst_async.store_data", o_store_data, 32'h0);
      check("rst_async.wr_reg", o_wr_reg, 5'd0);
      step();
      check("rst_held.valid", out_valid, 1'b0);
      rst_n = 1'b1;
      s2 = valid_stim(); s2.op = 3'b000; s2.d1 = 1; s2.d2 = 2; s2.rw = 1; s2.rt = 20;
      apply(s2);
      step();
      check_out("post_rst", mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd3, 32'd2, 5'd20));

      // ---- randomized single-cycle traffic against the model ----
      for (int n = 0; n < 300; n++) begin
         s.in_valid = ($urandom_range(0, 9) != 0);
         s.flush    = ($urandom_range(0, 9) == 0);
         s.rw  = 1'($urandom); s.m2r = 1'($urandom); s.mw = 1'($urandom);
         s.mr  = 1'($urandom); s.br  = 1'($urandom);
         s.op  = 3'($urandom); s.src = 1'($urandom); s.dst = 1'($urandom);
         s.fn  = fns[$urandom_range(0, 7)];
`ifdef EX_STAGE_MULT_EN
         if (s.fn == 6'h18) s.fn = 6'h20;
`endif
         s.pc  = $urandom; s.d1 = rnd_word(); s.d2 = rnd_word(); s.imm = rnd_word();
         if ($urandom_range(0, 3) == 0) begin
            s.d2  = s.d1;
            s.imm = s.d1;
         end
         s.rt = 5'($urandom); s.rd = 5'($urandom);
         apply(s);
         step();
         check_out("rand", model(s));
      end

`ifdef EX_STAGE_MULT_EN
      // ---- multiply: 31 stall cycles, bubbles, result on edge 32 ----
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h18; s.d1 = 32'h0000_FFFF; s.d2 = 32'h0001_0001;
      s.dst = 1; s.rd = 3; s.rw = 1;
      apply(s);
      stalls = 0;
      bubbles_bad = 0;
      for (int k = 1; k <= 32; k++) begin
         #2;
         if (stall_req === 1'b1) stalls++;
         if (k == 32) check("mul.stall_last", stall_req, 1'b0);
         step();
         if (k < 32 && out_valid !== 1'b0) bubbles_bad++;
      end
      check("mul.stall_cycles", stalls, 31);
      check("mul.bubbles_bad", bubbles_bad, 0);
      check_out("mul", mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h0001_0001, 5'd3));
      s2 = valid_stim(); s2.op = 3'b000; s2.d1 = 7; s2.d2 = 8; s2.rw = 1; s2.rt = 21;
      apply(s2);
      step();
      check_out("after_mul", model(s2));

      // ---- random multiply against the model ----
      s.d1 = $urandom; s.d2 = $urandom; s.rd = 5'($urandom);
      apply(s);
      repeat (32) step();
      check_out("mul_rand", model(s));

      // ---- flush at cnt == 10 aborts the multiply ----
      s.d1 = 32'h1234; s.d2 = 32'h5678;
      apply(s);
      repeat (10) step();
      #2;
      check("mflush.stall_before", stall_req, 1'b1);
      s.flush = 1'b1;
      apply(s);
      #1;
      check("mflush.stall_in_flush", stall_req, 1'b0);
      step();
      check("mflush.valid", out_valid, 1'b0);
      s2 = valid_stim(); s2.op = 3'b010; s2.fn = 6'h20; s2.d1 = 20; s2.d2 = 22; s2.rw = 1; s2.dst = 1; s2.rd = 4;
      apply(s2);
      #1;
      check("mflush.next_stall", stall_req, 1'b0);
      step();
      check_out("mflush.next_add", mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 32'd42, 32'd22, 5'd4));
`else
      // ---- without the multiplier, mult is an unlisted funct ----
      s = valid_stim(); s.op = 3'b010; s.fn = 6'h18; s.d1 = 32'h0000_FFFF; s.d2 = 32'h0001_0001;
      s.dst = 1; s.rd = 3; s.rw = 1;
      apply(s);
      #1;
      check("nomul.stall", stall_req, 1'b0);
      step();
      check_out("nomul", mk_exp(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0001_0001, 5'd3));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
